// File: rtl/comparator_2bit_pkg.sv
// Shared definitions for the 2-bit magnitude comparator: the one-hot compare
// result encoding, its bit positions and the default widths.
package comparator_2bit_pkg;

    // Default operand and counter widths
    localparam int DEF_W     = 2;
    localparam int DEF_CNT_W = 8;

    // Bit positions inside the one-hot result vector {GT, LT, EQ}
    localparam int EQ_IDX = 0;
    localparam int LT_IDX = 1;
    localparam int GT_IDX = 2;

    // Exactly one bit is set for any fully known operand pair
    typedef enum logic [2:0] {
        CMP_EQ = 3'b001,
        CMP_LT = 3'b010,
        CMP_GT = 3'b100
    } cmp_result_e;

endpackage

// File: rtl/comparator_2bit_cascade.sv
// Combinational W-bit unsigned comparator, MSB-first cascade: the first bit
// position (from the top) where the operands differ decides lt/gt; if no bit
// differs the operands are equal.
module cmp_bit_cascade #(
    parameter int W = 2
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         lt,
    output logic         gt
);

    logic decided;

    // Walk from the MSB down; the first differing bit fixes the result
    always_comb begin
        // NOTE: blocking assignments with defaults first keep this purely
        // combinational; a missing default here would infer a latch.
        decided = 1'b0;
        lt      = 1'b0;
        gt      = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (!decided && (a[i] ^ b[i])) begin
                gt      = a[i];
                lt      = b[i];
                decided = 1'b1;
            end
        end
        eq = ~decided;
    end

endmodule

// File: rtl/comparator_2bit.sv
// Unsigned magnitude comparator top: instant eq/lt/gt flags from the cascade,
// registered copies of those flags and three saturating outcome counters.
module comparator_2bit
    import comparator_2bit_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    output logic             A_eq_B,
    output logic             A_lt_B,
    output logic             A_gt_B,
    output logic             eq_q,
    output logic             lt_q,
    output logic             gt_q,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_gt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic        eq_c;
    logic        lt_c;
    logic        gt_c;
    cmp_result_e result;
    logic [2:0]  flags_q;
    logic [CNT_W-1:0] cnt_q [3];

    cmp_bit_cascade #(
        .W (W)
    ) u_cascade (
        .a  (A),
        .b  (B),
        .eq (eq_c),
        .lt (lt_c),
        .gt (gt_c)
    );

    // The compare path never touches the clock or reset
    assign A_eq_B = eq_c;
    assign A_lt_B = lt_c;
    assign A_gt_B = gt_c;
    assign result = cmp_result_e'({gt_c, lt_c, eq_c});

    // Capture the flags every edge; reset clears them asynchronously
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            flags_q <= '0;
        end else begin
            flags_q <= result;
        end
    end

    assign eq_q = flags_q[EQ_IDX];
    assign lt_q = flags_q[LT_IDX];
    assign gt_q = flags_q[GT_IDX];

    // One saturating counter per outcome; clr beats increment, rst beats clr
    for (genvar g = 0; g < 3; g++) begin : g_cnt
        // Count edges on which this outcome's flag is set, holding at max
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q[g] <= '0;
            end else if (clr) begin
                cnt_q[g] <= '0;
            end else if (result[g] && (cnt_q[g] != CNT_MAX)) begin
                cnt_q[g] <= cnt_q[g] + 1'b1;
            end
        end
    end

    assign cnt_eq = cnt_q[EQ_IDX];
    assign cnt_lt = cnt_q[LT_IDX];
    assign cnt_gt = cnt_q[GT_IDX];

endmodule

// File: tb/tb_comparator_2bit.sv
// Directed self-checking bench for comparator_2bit: combinational flags,
// registered flags, counters, async reset and counter saturation/clear.
module tb_comparator_2bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [1:0] a;
    logic [1:0] b;
    logic       a_eq_b, a_lt_b, a_gt_b;
    logic       eq_q, lt_q, gt_q;
    logic [7:0] cnt_eq, cnt_lt, cnt_gt;

    // Second instance with 2-bit counters for the saturation case
    logic       s_clr;
    logic [1:0] s_a;
    logic [1:0] s_b;
    logic       s_eq, s_lt, s_gt;
    logic       s_eq_q, s_lt_q, s_gt_q;
    logic [1:0] s_cnt_eq, s_cnt_lt, s_cnt_gt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    comparator_2bit #(.W(2), .CNT_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .A      (a),
        .B      (b),
        .A_eq_B (a_eq_b),
        .A_lt_B (a_lt_b),
        .A_gt_B (a_gt_b),
        .eq_q   (eq_q),
        .lt_q   (lt_q),
        .gt_q   (gt_q),
        .cnt_eq (cnt_eq),
        .cnt_lt (cnt_lt),
        .cnt_gt (cnt_gt)
    );

    comparator_2bit #(.W(2), .CNT_W(2)) dut_sat (
        .clk    (clk),
        .rst    (rst),
        .clr    (s_clr),
        .A      (s_a),
        .B      (s_b),
        .A_eq_B (s_eq),
        .A_lt_B (s_lt),
        .A_gt_B (s_gt),
        .eq_q   (s_eq_q),
        .lt_q   (s_lt_q),
        .gt_q   (s_gt_q),
        .cnt_eq (s_cnt_eq),
        .cnt_lt (s_cnt_lt),
        .cnt_gt (s_cnt_gt)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    initial begin
        rst   = 1'b1;
        clr   = 1'b0;
        s_clr = 1'b0;
        a     = 2'b00;
        b     = 2'b00;
        s_a   = 2'b00;
        s_b   = 2'b00;
        #12;

        // Reset state of registered outputs
        check("rst_eq_q", 32'(eq_q), 0);
        check("rst_lt_q", 32'(lt_q), 0);
        check("rst_gt_q", 32'(gt_q), 0);
        check("rst_cnt_eq", 32'(cnt_eq), 0);
        check("rst_cnt_lt", 32'(cnt_lt), 0);
        check("rst_cnt_gt", 32'(cnt_gt), 0);

        // Combinational directed vectors (registers held in reset)
        a = 2'b01; b = 2'b10; #10;
        check("c01_10_eq", 32'(a_eq_b), 0);
        check("c01_10_lt", 32'(a_lt_b), 1);
        check("c01_10_gt", 32'(a_gt_b), 0);
        a = 2'b11; b = 2'b01; #10;
        check("c11_01_eq", 32'(a_eq_b), 0);
        check("c11_01_lt", 32'(a_lt_b), 0);
        check("c11_01_gt", 32'(a_gt_b), 1);
        a = 2'b10; b = 2'b10; #10;
        check("c10_10_eq", 32'(a_eq_b), 1);

        // Exhaustive sweep against integer compare, plus one-hot check
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = i[1:0];
                b = j[1:0];
                #10;
                check($sformatf("sw_eq_%0d_%0d", i, j), 32'(a_eq_b), 32'(i == j));
                check($sformatf("sw_lt_%0d_%0d", i, j), 32'(a_lt_b), 32'(i < j));
                check($sformatf("sw_gt_%0d_%0d", i, j), 32'(a_gt_b), 32'(i > j));
                check($sformatf("sw_onehot_%0d_%0d", i, j), 32'($countones({a_eq_b, a_lt_b, a_gt_b})), 1);
            end
        end

        // Counting: 3 edges equal, then 2 edges A<B
        @(negedge clk);
        rst = 1'b0;
        a = 2'b10; b = 2'b10;
        s_a = 2'b11; s_b = 2'b01;
        s_clr = 1'b1;
        repeat (3) @(negedge clk);
        check("cnt_eq_after3", 32'(cnt_eq), 3);
        check("eq_q_after3", 32'(eq_q), 1);
        check("lt_q_before_change", 32'(lt_q), 0);
        a = 2'b00; b = 2'b11;
        @(negedge clk);
        check("lt_q_one_edge", 32'(lt_q), 1);
        check("eq_q_one_edge", 32'(eq_q), 0);
        check("cnt_lt_after1", 32'(cnt_lt), 1);
        @(negedge clk);
        check("seq_cnt_eq", 32'(cnt_eq), 3);
        check("seq_cnt_lt", 32'(cnt_lt), 2);
        check("seq_cnt_gt", 32'(cnt_gt), 0);

        // Async reset between edges: registers clear at once, flags still live
        #2 rst = 1'b1;
        #1;
        check("arst_lt_q", 32'(lt_q), 0);
        check("arst_cnt_eq", 32'(cnt_eq), 0);
        check("arst_cnt_lt", 32'(cnt_lt), 0);
        check("arst_comb_lt", 32'(a_lt_b), 1);
        a = 2'b11; b = 2'b01;
        #1;
        check("arst_comb_gt", 32'(a_gt_b), 1);
        check("arst_gt_q", 32'(gt_q), 0);
        @(negedge clk);
        check("arst_hold_cnt_gt", 32'(cnt_gt), 0);

        // Release: counting resumes from 0; clr then zeroes counters
        rst = 1'b0;
        a = 2'b01; b = 2'b01;
        @(negedge clk);
        check("resume_cnt_eq", 32'(cnt_eq), 1);
        check("resume_eq_q", 32'(eq_q), 1);
        @(negedge clk);
        check("resume_cnt_eq2", 32'(cnt_eq), 2);
        clr = 1'b1;
        a = 2'b10; b = 2'b01;
        @(negedge clk);
        check("clr_cnt_eq", 32'(cnt_eq), 0);
        check("clr_cnt_gt", 32'(cnt_gt), 0);
        check("clr_gt_q", 32'(gt_q), 1);
        clr = 1'b0;
        @(negedge clk);
        check("post_clr_cnt_gt", 32'(cnt_gt), 1);

        // Saturation on the 2-bit counter instance (A>B held)
        s_clr = 1'b1;
        @(negedge clk);
        check("sat_start", 32'(s_cnt_gt), 0);
        s_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("sat_cnt2", 32'(s_cnt_gt), 2);
        repeat (3) @(negedge clk);
        check("sat_cnt5", 32'(s_cnt_gt), 3);
        check("sat_cnt_lt", 32'(s_cnt_lt), 0);
        s_clr = 1'b1;
        @(negedge clk);
        check("sat_clr", 32'(s_cnt_gt), 0);
        s_clr = 1'b0;
        @(negedge clk);
        check("sat_after_clr", 32'(s_cnt_gt), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
